// File: rtl/perceptron_classifier.sv
// Two-input perceptron inference engine with a shared 14x7 signed multiplier.
// It classifies Q3.4 samples against loaded Q6.8 weights and keeps saturating error/sample statistics.
module perceptron_classifier (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_w,
    input  logic [13:0] w1_in,
    input  logic [13:0] w2_in,
    input  logic [13:0] b_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  x1_in,
    input  logic [6:0]  x2_in,
    input  logic [1:0]  t_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] y_in,
    output logic [1:0]  y_class,
    output logic        mismatch,
    input  logic        clr_stats,
    output logic [7:0]  err_count,
    output logic [7:0]  sample_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [13:0] w1;
    logic [13:0] w2;
    logic [13:0] b;
    logic [13:0] acc;
    logic [6:0]  x1;
    logic [6:0]  x2;
    logic [1:0]  t;
    logic [7:0]  err_cnt;
    logic [7:0]  smp_cnt;

    logic [13:0] mul_w;
    logic [6:0]  mul_x;
    logic [17:0] prod;
    logic [13:0] p;
    logic [3:0]  frac_unused;
    logic        t_unused;
    logic        accept;
    logic        handshake;

    // in_ready is gated by rst so it reads low for the whole reset pulse.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops see pre-edge values.
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = MUL1;
            MUL1:                   state_nx = MUL2;
            MUL2:                   state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Single multiplier: operands steered by the current multiply phase.
    always_comb begin
        mul_w = w1;
        mul_x = x1;
        if (state == MUL2) begin
            mul_w = w2;
            mul_x = x2;
        end
    end

    // Low 18 bits of the sign-extended product hold bits [17:4] of the 21-bit result,
    // which is the arithmetic shift by 4 truncated to 14 bits.
    assign prod             = {{4{mul_w[13]}}, mul_w} * {{11{mul_x[6]}}, mul_x};
    assign {p, frac_unused} = prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1 <= '0;
            w2 <= '0;
            b  <= '0;
        end else if (state == IDLE && ld_w) begin
            w1 <= w1_in;
            w2 <= w2_in;
            b  <= b_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
            x2 <= '0;
            t  <= '0;
        end else if (accept) begin
            x1 <= x1_in;
            x2 <= x2_in;
            t  <= t_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            case (state)
                MUL1:    acc <= b + p;
                MUL2:    acc <= acc + p;
                default: acc <= acc;
            endcase
        end
    end

    // Clear wins over a coincident handshake; both counters stick at 8'hFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            smp_cnt <= '0;
        end else if (clr_stats) begin
            err_cnt <= '0;
            smp_cnt <= '0;
        end else if (handshake) begin
            if (smp_cnt != 8'hFF) smp_cnt <= smp_cnt + 8'd1;
            if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    // Only the sign bit of the label matters: 01 is +1, 11 is -1.
    assign t_unused     = t[0];
    assign y_in         = acc;
    assign y_class      = acc[13] ? 2'b11 : 2'b01;
    assign mismatch     = (acc == 14'd0) || (acc[13] ^ t[1]);
    assign err_count    = err_cnt;
    assign sample_count = smp_cnt;

endmodule
